// File: rtl/uart_pkg.sv
// Shared types and constants for the UART PHY: FSM state encodings and frame geometry.
package uart_pkg;

   localparam int FRAME_BITS       = 10;   // start + 8 data + stop
   localparam int DATA_BITS        = 8;
   localparam int CLKS_PER_BIT_DEF = 104;  // 12 MHz / 115200

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered occupancy; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             push_ok, pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem[rd_ptr];

   // Storage array; contents need no reset since occupancy gates reads.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_phy.sv
// 8N1 UART PHY: CPU write strobes feed a TX FIFO serialized onto uart_tx;
// uart_rx is deserialized into a one-byte holding register with overrun flag.
// Optional macro UART_PHY_LOOPBACK_EN adds a loopback input routing TX to RX.
module uart_phy
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int TX_DEPTH     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart0_wr,
   input  logic [7:0] uart_w,
   input  logic       uart0_rd,
   output logic       uart0_valid,
   output logic [7:0] uart0_data,
   output logic       tx_ready,
   output logic       rx_overrun,
   output logic       uart_tx,
`ifdef UART_PHY_LOOPBACK_EN
   input  logic       loopback,
`endif
   input  logic       uart_rx
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

   // ---------------- TX ----------------
   logic       fifo_pop, fifo_full, fifo_empty;
   logic [7:0] fifo_dout;

   uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (uart0_wr),
      .pop   (fifo_pop),
      .din   (uart_w),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign tx_ready = !fifo_full;

   tx_state_t     tx_state, tx_state_n;
   logic [CW-1:0] tx_cnt, tx_cnt_n;
   logic [3:0]    tx_idx, tx_idx_n;
   logic [7:0]    tx_sh, tx_sh_n;
   logic          tx_bit, tx_bit_n;

   // TX state register; tx_bit resets high so the line idles at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_sh    <= '0;
         tx_bit   <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_idx   <= tx_idx_n;
         tx_sh    <= tx_sh_n;
         tx_bit   <= tx_bit_n;
      end
   end

   // TX next state: each bit held CLKS_PER_BIT cycles; STOP chains into START when data waits.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_idx_n   = tx_idx;
      tx_sh_n    = tx_sh;
      tx_bit_n   = tx_bit;
      fifo_pop   = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               tx_sh_n    = fifo_dout;
               tx_bit_n   = 1'b0;
               tx_cnt_n   = '0;
               tx_state_n = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt == CNT_MAX) begin
               tx_cnt_n   = '0;
               tx_idx_n   = '0;
               tx_bit_n   = tx_sh[0];
               tx_state_n = TX_DATA;
            end else tx_cnt_n = tx_cnt + 1'b1;
         end
         TX_DATA: begin
            if (tx_cnt == CNT_MAX) begin
               tx_cnt_n = '0;
               if (tx_idx == LAST_BIT) begin
                  tx_bit_n   = 1'b1;
                  tx_state_n = TX_STOP;
               end else begin
                  tx_idx_n = tx_idx + 4'd1;
                  tx_sh_n  = {1'b0, tx_sh[7:1]};
                  tx_bit_n = tx_sh[1];
               end
            end else tx_cnt_n = tx_cnt + 1'b1;
         end
         TX_STOP: begin
            if (tx_cnt == CNT_MAX) begin
               tx_cnt_n = '0;
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  tx_sh_n    = fifo_dout;
                  tx_bit_n   = 1'b0;
                  tx_state_n = TX_START;
               end else tx_state_n = TX_IDLE;
            end else tx_cnt_n = tx_cnt + 1'b1;
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end

   // ---------------- RX ----------------
   logic rx_src, rx_meta, rx_s, rx_d;

`ifdef UART_PHY_LOOPBACK_EN
   assign rx_src  = loopback ? tx_bit : uart_rx;
   assign uart_tx = loopback ? 1'b1 : tx_bit;
`else
   assign rx_src  = uart_rx;
   assign uart_tx = tx_bit;
`endif

   // Two-flop synchronizer plus one delay stage for falling-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= rx_src;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   rx_state_t     rx_state, rx_state_n;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [3:0]    rx_idx, rx_idx_n;
   logic [7:0]    rx_sh, rx_sh_n;
   logic          rx_ferr, rx_ferr_n;
   logic          rx_done;

   // RX state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_sh    <= '0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_idx   <= rx_idx_n;
         rx_sh    <= rx_sh_n;
         rx_ferr  <= rx_ferr_n;
      end
   end

   // RX next state: centre-sample start, data and stop; a low stop bit parks in STOP until the line rises.
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_idx_n   = rx_idx;
      rx_sh_n    = rx_sh;
      rx_ferr_n  = rx_ferr;
      rx_done    = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_d && !rx_s) begin
               rx_cnt_n   = '0;
               rx_state_n = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt == CNT_HALF) begin
               rx_cnt_n   = '0;
               rx_idx_n   = '0;
               rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            end else rx_cnt_n = rx_cnt + 1'b1;
         end
         RX_DATA: begin
            if (rx_cnt == CNT_MAX) begin
               rx_cnt_n = '0;
               rx_sh_n  = {rx_s, rx_sh[7:1]};
               if (rx_idx == LAST_BIT) begin
                  rx_ferr_n  = 1'b0;
                  rx_state_n = RX_STOP;
               end else rx_idx_n = rx_idx + 4'd1;
            end else rx_cnt_n = rx_cnt + 1'b1;
         end
         RX_STOP: begin
            if (rx_ferr) begin
               if (rx_s) begin
                  rx_ferr_n  = 1'b0;
                  rx_state_n = RX_IDLE;
               end
            end else if (rx_cnt == CNT_MAX) begin
               rx_cnt_n = '0;
               if (rx_s) begin
                  rx_done    = 1'b1;
                  rx_state_n = RX_IDLE;
               end else rx_ferr_n = 1'b1;
            end else rx_cnt_n = rx_cnt + 1'b1;
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   // Holding register: a landing byte beats a same-cycle read; overrun only when unread data is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uart0_valid <= 1'b0;
         uart0_data  <= '0;
         rx_overrun  <= 1'b0;
      end else if (rx_done) begin
         uart0_data  <= rx_sh;
         uart0_valid <= 1'b1;
         if (uart0_valid && !uart0_rd) rx_overrun <= 1'b1;
      end else if (uart0_rd && uart0_valid) begin
         uart0_valid <= 1'b0;
         rx_overrun  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_phy.sv
// Directed bench for uart_phy at CLKS_PER_BIT=4, TX_DEPTH=16.
module tb_uart_phy;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       uart0_wr;
   logic [7:0] uart_w;
   logic       uart0_rd;
   logic       uart0_valid;
   logic [7:0] uart0_data;
   logic       tx_ready;
   logic       rx_overrun;
   logic       uart_tx;
   logic       uart_rx;
`ifdef UART_PHY_LOOPBACK_EN
   logic       loopback = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   uart_phy #(.CLKS_PER_BIT(CPB), .TX_DEPTH(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .uart0_wr    (uart0_wr),
      .uart_w      (uart_w),
      .uart0_rd    (uart0_rd),
      .uart0_valid (uart0_valid),
      .uart0_data  (uart0_data),
      .tx_ready    (tx_ready),
      .rx_overrun  (rx_overrun),
      .uart_tx     (uart_tx),
`ifdef UART_PHY_LOOPBACK_EN
      .loopback    (loopback),
`endif
      .uart_rx     (uart_rx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one 8N1 frame; returns in the cycle right after the stop bit.
   task automatic send_rx(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) tick();
      end
      uart_rx = stop;
      repeat (CPB) tick();
      uart_rx = 1'b1;
   endtask

   task automatic rd_pulse();
      uart0_rd = 1'b1;
      tick();
      uart0_rd = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({uart_tx, uart0_valid, uart0_data, rx_overrun, tx_ready} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: tx=%b valid=%b data=%h ovr=%b rdy=%b", uart_tx, uart0_valid, uart0_data, rx_overrun, tx_ready);
      end
      reset = 1'b0;
      tick();
      // put state in every output, then reset mid-frame
      send_rx(8'h5A, 1'b1);
      tick();
      for (int i = 0; i < 17; i++) begin
         uart0_wr = 1'b1;
         uart_w   = 8'(i);
         tick();
      end
      uart0_wr = 1'b0;
      checks++;
      if ({uart_tx, uart0_valid, tx_ready} !== 3'b010) begin
         errors++;
         $display("FAIL pre_reset: tx=%b valid=%b rdy=%b expected 0 1 0", uart_tx, uart0_valid, tx_ready);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({uart_tx, uart0_valid, uart0_data, rx_overrun, tx_ready} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_midframe: tx=%b valid=%b data=%h ovr=%b rdy=%b", uart_tx, uart0_valid, uart0_data, rx_overrun, tx_ready);
      end
      tick();
      tick();
      reset = 1'b0;
      repeat (2) tick();
      checks++;
      if (uart_tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle_after: tx=%b expected 1", uart_tx);
      end
   endtask

   task automatic test_tx_single();
      logic [7:0] b;
      logic       exp;
      b = 8'h55;
      uart0_wr = 1'b1;
      uart_w   = b;
      for (int c = 1; c <= 48; c++) begin
         tick();
         uart0_wr = 1'b0;
         if (c < 2)       exp = 1'b1;
         else if (c < 6)  exp = 1'b0;
         else if (c < 38) exp = b[(c - 6) / 4];
         else             exp = 1'b1;
         checks++;
         if (uart_tx !== exp) begin
            errors++;
            $display("FAIL tx_single cycle %0d: tx=%b expected %b", c, uart_tx, exp);
         end
      end
   endtask

   task automatic test_tx_burst();
      logic [9:0] obs [17];
      logic [9:0] exp;
      logic       idle_ok;
      int         k, off;
      idle_ok = 1'b1;
      for (int c = 0; c <= 700; c++) begin
         uart0_wr = (c < 18);
         uart_w   = 8'(c);
         if (c == 16 || c == 17 || c == 18 || c == 41 || c == 42) begin
            checks++;
            if (tx_ready !== (c == 16 || c == 42)) begin
               errors++;
               $display("FAIL tx_ready cycle %0d: got %b expected %b", c, tx_ready, (c == 16 || c == 42));
            end
         end
         if (c >= 2 && c < 682) begin
            k   = (c - 2) / 40;
            off = (c - 2) % 40;
            if (off % 4 == 2) obs[k][off / 4] = uart_tx;
         end else if (c >= 682) begin
            if (uart_tx !== 1'b1) idle_ok = 1'b0;
         end
         tick();
      end
      uart0_wr = 1'b0;
      for (int f = 0; f < 17; f++) begin
         exp = {1'b1, 8'(f), 1'b0};
         checks++;
         if (obs[f] !== exp) begin
            errors++;
            $display("FAIL tx_burst frame %0d: got %b expected %b", f, obs[f], exp);
         end
      end
      checks++;
      if (idle_ok !== 1'b1) begin
         errors++;
         $display("FAIL tx_burst_drop: line not idle after 17 frames (0x11 should be dropped)");
      end
   endtask

   task automatic test_rx_byte();
      send_rx(8'hA3, 1'b1);
      checks++;
      if (uart0_valid !== 1'b0) begin
         errors++;
         $display("FAIL rx_early_valid: got %b expected 0", uart0_valid);
      end
      tick();
      checks++;
      if ({uart0_valid, uart0_data, rx_overrun} !== {1'b1, 8'hA3, 1'b0}) begin
         errors++;
         $display("FAIL rx_byte: valid=%b data=%h ovr=%b expected 1 a3 0", uart0_valid, uart0_data, rx_overrun);
      end
      rd_pulse();
      checks++;
      if ({uart0_valid, uart0_data} !== {1'b0, 8'hA3}) begin
         errors++;
         $display("FAIL rx_rd_clear: valid=%b data=%h expected 0 a3", uart0_valid, uart0_data);
      end
      rd_pulse();
      checks++;
      if ({uart0_valid, rx_overrun} !== 2'b00) begin
         errors++;
         $display("FAIL rx_rd_idle: valid=%b ovr=%b expected 0 0", uart0_valid, rx_overrun);
      end
   endtask

   task automatic test_rx_errors();
      uart_rx = 1'b0;
      tick();
      uart_rx = 1'b1;
      repeat (12) tick();
      checks++;
      if (uart0_valid !== 1'b0) begin
         errors++;
         $display("FAIL rx_glitch: valid=%b expected 0", uart0_valid);
      end
      send_rx(8'h3C, 1'b0);
      repeat (6) tick();
      checks++;
      if (uart0_valid !== 1'b0) begin
         errors++;
         $display("FAIL rx_framing: valid=%b expected 0", uart0_valid);
      end
      repeat (4) tick();
      send_rx(8'h3C, 1'b1);
      tick();
      checks++;
      if ({uart0_valid, uart0_data} !== {1'b1, 8'h3C}) begin
         errors++;
         $display("FAIL rx_after_ferr: valid=%b data=%h expected 1 3c", uart0_valid, uart0_data);
      end
      rd_pulse();
   endtask

   task automatic test_overrun();
      send_rx(8'h11, 1'b1);
      repeat (3) tick();
      send_rx(8'h22, 1'b1);
      tick();
      checks++;
      if ({uart0_valid, uart0_data, rx_overrun} !== {1'b1, 8'h22, 1'b1}) begin
         errors++;
         $display("FAIL overrun: valid=%b data=%h ovr=%b expected 1 22 1", uart0_valid, uart0_data, rx_overrun);
      end
      rd_pulse();
      checks++;
      if ({uart0_valid, rx_overrun} !== 2'b00) begin
         errors++;
         $display("FAIL overrun_clear: valid=%b ovr=%b expected 0 0", uart0_valid, rx_overrun);
      end
      send_rx(8'h33, 1'b1);
      tick();
      repeat (3) tick();
      send_rx(8'h44, 1'b1);
      // new byte lands in this cycle: read coincides with it
      uart0_rd = 1'b1;
      tick();
      uart0_rd = 1'b0;
      checks++;
      if ({uart0_valid, uart0_data, rx_overrun} !== {1'b1, 8'h44, 1'b0}) begin
         errors++;
         $display("FAIL rd_same_cycle: valid=%b data=%h ovr=%b expected 1 44 0", uart0_valid, uart0_data, rx_overrun);
      end
      rd_pulse();
      checks++;
      if (uart0_valid !== 1'b0) begin
         errors++;
         $display("FAIL final_rd: valid=%b expected 0", uart0_valid);
      end
   endtask

   initial begin
      reset    = 1'b1;
      uart0_wr = 1'b0;
      uart_w   = 8'h00;
      uart0_rd = 1'b0;
      uart_rx  = 1'b1;
      test_reset();
      test_tx_single();
      test_tx_burst();
      test_rx_byte();
      test_rx_errors();
      test_overrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
